// File: rtl/rs_issue_scheduler.sv
// rs_issue_scheduler: reservation station with CDB wakeup and oldest-first multi-port issue.
// Define RS_PERF_COUNTERS_EN to add the perf_issued / perf_full_cycles counters.
module rs_issue_scheduler #(
  parameter int SS = 2,
  parameter int RS_DEPTH = 8,
  parameter int NUM_FU = 2,
  parameter int PR_ENTRIES = 64,
  parameter int ROB_DEPTH = 8,
  parameter int PAYLOAD_W = 64,
  localparam int PRW = $clog2(PR_ENTRIES),
  localparam int RW = $clog2(ROB_DEPTH),
  localparam int OW = $clog2(RS_DEPTH + 1),
  localparam int IW = $clog2(RS_DEPTH)
) (
  input  logic clk,
  input  logic rst,
  input  logic flush,
  input  logic [SS-1:0] dispatch_valid,
  input  logic [SS*RW-1:0] dispatch_rob_id,
  input  logic [SS*PRW-1:0] dispatch_prs1,
  input  logic [SS*PRW-1:0] dispatch_prs2,
  input  logic [SS-1:0] dispatch_rs1_met,
  input  logic [SS-1:0] dispatch_rs2_met,
  input  logic [SS*PRW-1:0] dispatch_prd,
  input  logic [SS*PAYLOAD_W-1:0] dispatch_payload,
  output logic rs_full,
  input  logic [SS-1:0] cdb_valid,
  input  logic [SS*PRW-1:0] cdb_prd,
  output logic [NUM_FU-1:0] issue_valid,
  input  logic [NUM_FU-1:0] issue_ready,
  output logic [NUM_FU*RW-1:0] issue_rob_id,
  output logic [NUM_FU*PRW-1:0] issue_prs1,
  output logic [NUM_FU*PRW-1:0] issue_prs2,
  output logic [NUM_FU*PRW-1:0] issue_prd,
  output logic [NUM_FU*PAYLOAD_W-1:0] issue_payload,
  output logic [OW-1:0] occupancy
`ifdef RS_PERF_COUNTERS_EN
  ,
  output logic [31:0] perf_issued,
  output logic [31:0] perf_full_cycles
`endif
);
  logic [RS_DEPTH-1:0] valid, met1, met2, wake1, wake2, rdy, cand, taken;
  logic [RS_DEPTH-1:0] age [RS_DEPTH];
  logic [RW-1:0] rob [RS_DEPTH];
  logic [PRW-1:0] prs1 [RS_DEPTH];
  logic [PRW-1:0] prs2 [RS_DEPTH];
  logic [PRW-1:0] prd [RS_DEPTH];
  logic [PAYLOAD_W-1:0] payload [RS_DEPTH];
  logic [IW-1:0] sel_idx [NUM_FU];
  logic [IW-1:0] alloc_idx [SS];
  logic [SS-1:0] alloc_ok;
  logic oldest;

  function automatic logic cdb_hit(input logic [PRW-1:0] t, input logic [SS-1:0] v,
                                   input logic [SS*PRW-1:0] p);
    cdb_hit = 1'b0;
    for (int l = 0; l < SS; l++) if (v[l] && p[l*PRW +: PRW] == t) cdb_hit = 1'b1;
  endfunction

  always_comb begin
    occupancy = '0;
    for (int i = 0; i < RS_DEPTH; i++) occupancy = occupancy + OW'(valid[i]);
  end

  assign rs_full = (RS_DEPTH - int'(occupancy)) < SS;
  assign rdy = valid & met1 & met2;

  always_comb begin
    wake1 = '0;
    wake2 = '0;
    for (int i = 0; i < RS_DEPTH; i++) begin
      wake1[i] = cdb_hit(prs1[i], cdb_valid, cdb_prd);
      wake2[i] = cdb_hit(prs2[i], cdb_valid, cdb_prd);
    end
  end

  // Each valid lane claims the lowest free slot not already claimed by a lower lane.
  always_comb begin
    taken = valid;
    for (int l = 0; l < SS; l++) begin
      alloc_ok[l] = 1'b0;
      alloc_idx[l] = '0;
      for (int i = 0; i < RS_DEPTH; i++)
        if (dispatch_valid[l] && !rs_full && !flush && !taken[i] && !alloc_ok[l]) begin
          alloc_ok[l] = 1'b1;
          alloc_idx[l] = IW'(i);
        end
      if (alloc_ok[l]) taken[alloc_idx[l]] = 1'b1;
    end
  end

  // An entry is oldest when its age bit is set against every other remaining candidate.
  always_comb begin
    cand = rdy;
    oldest = 1'b0;
    issue_rob_id = '0;
    issue_prs1 = '0;
    issue_prs2 = '0;
    issue_prd = '0;
    issue_payload = '0;
    for (int k = 0; k < NUM_FU; k++) begin
      issue_valid[k] = 1'b0;
      sel_idx[k] = '0;
      for (int i = 0; i < RS_DEPTH; i++) begin
        oldest = cand[i];
        for (int j = 0; j < RS_DEPTH; j++) if (j != i && cand[j] && !age[i][j]) oldest = 1'b0;
        if (oldest) begin
          issue_valid[k] = 1'b1;
          sel_idx[k] = IW'(i);
        end
      end
      if (issue_valid[k]) cand[sel_idx[k]] = 1'b0;
      issue_rob_id[k*RW +: RW] = issue_valid[k] ? rob[sel_idx[k]] : '0;
      issue_prs1[k*PRW +: PRW] = issue_valid[k] ? prs1[sel_idx[k]] : '0;
      issue_prs2[k*PRW +: PRW] = issue_valid[k] ? prs2[sel_idx[k]] : '0;
      issue_prd[k*PRW +: PRW] = issue_valid[k] ? prd[sel_idx[k]] : '0;
      issue_payload[k*PAYLOAD_W +: PAYLOAD_W] = issue_valid[k] ? payload[sel_idx[k]] : '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid <= '0;
      met1 <= '0;
      met2 <= '0;
      for (int i = 0; i < RS_DEPTH; i++) age[i] <= '0;
    end else if (flush) begin
      valid <= '0;
    end else begin
      met1 <= met1 | wake1;
      met2 <= met2 | wake2;
      for (int k = 0; k < NUM_FU; k++)
        if (issue_valid[k] && issue_ready[k]) valid[sel_idx[k]] <= 1'b0;
      for (int l = 0; l < SS; l++)
        if (alloc_ok[l]) begin
          valid[alloc_idx[l]] <= 1'b1;
          rob[alloc_idx[l]] <= dispatch_rob_id[l*RW +: RW];
          prs1[alloc_idx[l]] <= dispatch_prs1[l*PRW +: PRW];
          prs2[alloc_idx[l]] <= dispatch_prs2[l*PRW +: PRW];
          prd[alloc_idx[l]] <= dispatch_prd[l*PRW +: PRW];
          payload[alloc_idx[l]] <= dispatch_payload[l*PAYLOAD_W +: PAYLOAD_W];
          met1[alloc_idx[l]] <= dispatch_rs1_met[l] || dispatch_prs1[l*PRW +: PRW] == '0 ||
                                cdb_hit(dispatch_prs1[l*PRW +: PRW], cdb_valid, cdb_prd);
          met2[alloc_idx[l]] <= dispatch_rs2_met[l] || dispatch_prs2[l*PRW +: PRW] == '0 ||
                                cdb_hit(dispatch_prs2[l*PRW +: PRW], cdb_valid, cdb_prd);
          age[alloc_idx[l]] <= '0;
          for (int i = 0; i < RS_DEPTH; i++) age[i][alloc_idx[l]] <= valid[i];
          for (int m = 0; m < l; m++) if (alloc_ok[m]) age[alloc_idx[m]][alloc_idx[l]] <= 1'b1;
        end
    end
  end

`ifdef RS_PERF_COUNTERS_EN
  logic [NUM_FU-1:0] fire;
  assign fire = flush ? '0 : issue_valid & issue_ready;
  always_ff @(posedge clk) begin
    if (rst) begin
      perf_issued <= '0;
      perf_full_cycles <= '0;
    end else begin
      perf_issued <= perf_issued + 32'($countones(fire));
      if (rs_full && |dispatch_valid) perf_full_cycles <= perf_full_cycles + 32'd1;
    end
  end
`endif
endmodule

// File: tb/tb_rs_issue_scheduler.sv
// tb_rs_issue_scheduler: directed scenarios plus randomized traffic against an age-ordered queue model.
module tb_rs_issue_scheduler;
  localparam int SS = 2, D = 8, NF = 2, PRW = 6, RW = 3, PW = 64;
  logic clk = 1'b0;
  logic rst, flush, rs_full;
  logic [SS-1:0] dispatch_valid, dispatch_rs1_met, dispatch_rs2_met, cdb_valid;
  logic [SS*RW-1:0] dispatch_rob_id;
  logic [SS*PRW-1:0] dispatch_prs1, dispatch_prs2, dispatch_prd, cdb_prd;
  logic [SS*PW-1:0] dispatch_payload;
  logic [NF-1:0] issue_valid, issue_ready;
  logic [NF*RW-1:0] issue_rob_id;
  logic [NF*PRW-1:0] issue_prs1, issue_prs2, issue_prd;
  logic [NF*PW-1:0] issue_payload;
  logic [3:0] occupancy;
  int checks = 0, failures = 0;

  typedef struct {
    logic [RW-1:0] rob;
    logic [PRW-1:0] p1, p2, prd;
    bit m1, m2;
    logic [PW-1:0] pl;
  } ent_t;
  ent_t q[$];
  bit exp_full;
  int exp_occ;
  bit exp_iv[NF];
  int exp_idx[NF];

  rs_issue_scheduler dut (
    .clk(clk), .rst(rst), .flush(flush),
    .dispatch_valid(dispatch_valid), .dispatch_rob_id(dispatch_rob_id),
    .dispatch_prs1(dispatch_prs1), .dispatch_prs2(dispatch_prs2),
    .dispatch_rs1_met(dispatch_rs1_met), .dispatch_rs2_met(dispatch_rs2_met),
    .dispatch_prd(dispatch_prd), .dispatch_payload(dispatch_payload),
    .rs_full(rs_full), .cdb_valid(cdb_valid), .cdb_prd(cdb_prd),
    .issue_valid(issue_valid), .issue_ready(issue_ready),
    .issue_rob_id(issue_rob_id), .issue_prs1(issue_prs1), .issue_prs2(issue_prs2),
    .issue_prd(issue_prd), .issue_payload(issue_payload), .occupancy(occupancy)
  );

  always #5 clk = ~clk;

  function automatic bit hit(logic [PRW-1:0] t);
    for (int l = 0; l < SS; l++) if (cdb_valid[l] && cdb_prd[l*PRW +: PRW] == t) return 1'b1;
    return 1'b0;
  endfunction

  // Queue is kept oldest-first; the first NF ready entries are what the ports must show.
  task automatic model_eval();
    int k;
    k = 0;
    exp_occ = q.size();
    exp_full = (D - exp_occ) < SS;
    for (int p = 0; p < NF; p++) begin exp_iv[p] = 1'b0; exp_idx[p] = 0; end
    foreach (q[i]) if (q[i].m1 && q[i].m2 && k < NF) begin exp_iv[k] = 1'b1; exp_idx[k] = i; k++; end
  endtask

  task automatic model_edge();
    ent_t nq[$];
    ent_t e;
    bit fired;
    if (rst || flush) begin q.delete(); return; end
    foreach (q[i]) begin
      fired = 1'b0;
      for (int k = 0; k < NF; k++) if (exp_iv[k] && issue_ready[k] && exp_idx[k] == i) fired = 1'b1;
      e = q[i];
      if (hit(e.p1)) e.m1 = 1'b1;
      if (hit(e.p2)) e.m2 = 1'b1;
      if (!fired) nq.push_back(e);
    end
    if (!exp_full)
      for (int l = 0; l < SS; l++) if (dispatch_valid[l]) begin
        e.rob = dispatch_rob_id[l*RW +: RW];
        e.p1 = dispatch_prs1[l*PRW +: PRW];
        e.p2 = dispatch_prs2[l*PRW +: PRW];
        e.prd = dispatch_prd[l*PRW +: PRW];
        e.pl = dispatch_payload[l*PW +: PW];
        e.m1 = dispatch_rs1_met[l] || e.p1 == 0 || hit(e.p1);
        e.m2 = dispatch_rs2_met[l] || e.p2 == 0 || hit(e.p2);
        nq.push_back(e);
      end
    q = nq;
  endtask

  task automatic settle();
    @(negedge clk);
    model_eval();
  endtask

  task automatic tick();
    model_edge();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    rst = 0; flush = 0; dispatch_valid = 0; dispatch_rs1_met = 0; dispatch_rs2_met = 0;
    dispatch_rob_id = 0; dispatch_prs1 = 0; dispatch_prs2 = 0; dispatch_prd = 0;
    dispatch_payload = 0; cdb_valid = 0; cdb_prd = 0; issue_ready = 0;
  endtask

  task automatic set_lane(int l, int rob, int p1, int p2, bit m1, bit m2);
    dispatch_valid[l] = 1'b1;
    dispatch_rob_id[l*RW +: RW] = RW'(rob);
    dispatch_prs1[l*PRW +: PRW] = PRW'(p1);
    dispatch_prs2[l*PRW +: PRW] = PRW'(p2);
    dispatch_rs1_met[l] = m1;
    dispatch_rs2_met[l] = m2;
    dispatch_prd[l*PRW +: PRW] = PRW'($urandom_range(1, 63));
    dispatch_payload[l*PW +: PW] = {$urandom, $urandom};
  endtask

  task automatic test_reset();
    idle(); rst = 1; settle(); tick(); settle(); tick();
    idle(); set_lane(0, 1, 0, 0, 1, 1); set_lane(1, 2, 0, 0, 1, 1); settle(); tick();
    idle(); rst = 1; flush = 1; set_lane(0, 3, 0, 0, 1, 1); settle(); tick();
    idle(); settle();
    checks++; if (occupancy !== 4'd0) begin failures++; $display("FAIL reset_occ got=%0d exp=0", occupancy); end
    checks++; if (rs_full !== 1'b0) begin failures++; $display("FAIL reset_full got=%0b exp=0", rs_full); end
    checks++; if (issue_valid !== 2'b00) begin failures++; $display("FAIL reset_iv got=%0b exp=0", issue_valid); end
    checks++; if (issue_payload !== '0 || issue_rob_id !== '0 || issue_prd !== '0) begin
      failures++; $display("FAIL reset_fields got=%0h/%0h/%0h exp=0", issue_payload, issue_rob_id, issue_prd); end
    tick();
  endtask

  task automatic test_basic();
    idle(); set_lane(0, 0, 1, 2, 1, 1); set_lane(1, 1, 3, 4, 1, 1); issue_ready = 2'b11; settle();
    checks++; if (issue_valid !== 2'b00) begin failures++; $display("FAIL basic_early got=%0b exp=00", issue_valid); end
    tick();
    idle(); issue_ready = 2'b11; settle();
    checks++; if (issue_valid !== 2'b11) begin failures++; $display("FAIL basic_iv got=%0b exp=11", issue_valid); end
    checks++; if (issue_rob_id !== 6'b001_000) begin failures++; $display("FAIL basic_rob got=%0h exp=8", issue_rob_id); end
    checks++; if (occupancy !== 4'd2) begin failures++; $display("FAIL basic_occ2 got=%0d exp=2", occupancy); end
    tick(); idle(); settle();
    checks++; if (occupancy !== 4'd0) begin failures++; $display("FAIL basic_occ0 got=%0d exp=0", occupancy); end
    tick();
  endtask

  task automatic test_full();
    for (int c = 0; c < 3; c++) begin
      idle(); set_lane(0, 2*c, 10+2*c, 0, 0, 1); set_lane(1, 2*c+1, 11+2*c, 0, 0, 1); settle(); tick();
    end
    idle(); set_lane(0, 6, 16, 0, 0, 1); settle();
    checks++; if (rs_full !== 1'b0) begin failures++; $display("FAIL full_at6 got=%0b exp=0", rs_full); end
    tick();
    idle(); set_lane(0, 7, 17, 0, 0, 1); set_lane(1, 7, 18, 0, 0, 1); settle();
    checks++; if (occupancy !== 4'd7 || rs_full !== 1'b1) begin
      failures++; $display("FAIL full_at7 got=%0d/%0b exp=7/1", occupancy, rs_full); end
    tick();
    idle(); cdb_valid = 2'b01; cdb_prd[5:0] = 6'd12; settle();
    checks++; if (occupancy !== 4'd7) begin failures++; $display("FAIL full_ignored got=%0d exp=7", occupancy); end
    tick();
    idle(); issue_ready = 2'b01; settle();
    checks++; if (issue_valid !== 2'b01 || issue_rob_id[2:0] !== 3'd2) begin
      failures++; $display("FAIL full_issue got=%0b/%0d exp=01/2", issue_valid, issue_rob_id[2:0]); end
    tick();
    idle(); settle();
    checks++; if (occupancy !== 4'd6 || rs_full !== 1'b0) begin
      failures++; $display("FAIL full_release got=%0d/%0b exp=6/0", occupancy, rs_full); end
    tick(); flush = 1; settle(); tick();
  endtask

  task automatic test_wakeup();
    idle(); set_lane(0, 3, 5, 0, 0, 1); settle(); tick();
    idle(); settle();
    checks++; if (issue_valid !== 2'b00) begin failures++; $display("FAIL wake_wait got=%0b exp=00", issue_valid); end
    tick();
    idle(); cdb_valid = 2'b01; cdb_prd[5:0] = 6'd5; settle();
    checks++; if (issue_valid !== 2'b00) begin failures++; $display("FAIL wake_same got=%0b exp=00", issue_valid); end
    tick();
    idle(); issue_ready = 2'b01; settle();
    checks++; if (issue_valid !== 2'b01 || issue_rob_id[2:0] !== 3'd3) begin
      failures++; $display("FAIL wake_issue got=%0b/%0d exp=01/3", issue_valid, issue_rob_id[2:0]); end
    tick();
    idle(); set_lane(0, 4, 9, 0, 0, 1); cdb_valid = 2'b10; cdb_prd[11:6] = 6'd9; settle(); tick();
    idle(); issue_ready = 2'b01; settle();
    checks++; if (issue_valid !== 2'b01 || issue_rob_id[2:0] !== 3'd4) begin
      failures++; $display("FAIL wake_bypass got=%0b/%0d exp=01/4", issue_valid, issue_rob_id[2:0]); end
    tick(); idle(); settle();
    checks++; if (occupancy !== 4'd0) begin failures++; $display("FAIL wake_empty got=%0d exp=0", occupancy); end
    tick();
  endtask

  task automatic test_age_order();
    idle(); set_lane(0, 1, 0, 0, 1, 1); set_lane(1, 2, 0, 0, 1, 1); settle(); tick();
    idle(); set_lane(0, 3, 0, 0, 1, 1); settle(); tick();
    idle(); issue_ready = 2'b01; settle();
    checks++; if (issue_valid !== 2'b11 || issue_rob_id !== 6'b010_001) begin
      failures++; $display("FAIL age_first got=%0b/%0h exp=11/11", issue_valid, issue_rob_id); end
    tick();
    idle(); issue_ready = 2'b11; settle();
    checks++; if (issue_rob_id !== 6'b011_010 || occupancy !== 4'd2) begin
      failures++; $display("FAIL age_second got=%0h/%0d exp=1a/2", issue_rob_id, occupancy); end
    tick(); idle(); settle();
    checks++; if (occupancy !== 4'd0) begin failures++; $display("FAIL age_empty got=%0d exp=0", occupancy); end
    tick();
  endtask

  task automatic test_no_sticky();
    idle(); set_lane(0, 5, 20, 0, 0, 1); set_lane(1, 6, 21, 0, 0, 1); settle(); tick();
    idle(); set_lane(0, 7, 0, 0, 1, 1); settle(); tick();
    idle(); settle();
    checks++; if (issue_valid !== 2'b01 || issue_rob_id[2:0] !== 3'd7) begin
      failures++; $display("FAIL sticky_young got=%0b/%0d exp=01/7", issue_valid, issue_rob_id[2:0]); end
    tick();
    idle(); cdb_valid = 2'b01; cdb_prd[5:0] = 6'd20; settle();
    checks++; if (issue_rob_id[2:0] !== 3'd7) begin failures++; $display("FAIL sticky_hold got=%0d exp=7", issue_rob_id[2:0]); end
    tick();
    idle(); settle();
    checks++; if (issue_valid !== 2'b11 || issue_rob_id !== 6'b111_101) begin
      failures++; $display("FAIL sticky_switch got=%0b/%0h exp=11/3d", issue_valid, issue_rob_id); end
    tick(); flush = 1; settle(); tick();
  endtask

  task automatic test_flush();
    idle(); set_lane(0, 0, 0, 0, 1, 1); set_lane(1, 1, 0, 0, 1, 1); settle(); tick();
    idle(); set_lane(0, 2, 0, 0, 1, 1); set_lane(1, 3, 0, 0, 1, 1); settle(); tick();
    idle(); set_lane(0, 4, 0, 0, 1, 1); settle(); tick();
    idle(); flush = 1; set_lane(0, 5, 0, 0, 1, 1); set_lane(1, 6, 0, 0, 1, 1); issue_ready = 2'b11; settle();
    checks++; if (occupancy !== 4'd5) begin failures++; $display("FAIL flush_before got=%0d exp=5", occupancy); end
    tick();
    idle(); settle();
    checks++; if (occupancy !== 4'd0 || issue_valid !== 2'b00) begin
      failures++; $display("FAIL flush_after got=%0d/%0b exp=0/00", occupancy, issue_valid); end
    tick();
  endtask

  task automatic test_random();
    ent_t e;
    idle(); flush = 1; settle(); tick();
    for (int c = 0; c < 600; c++) begin
      idle();
      for (int l = 0; l < SS; l++) begin
        if ($urandom_range(0, 2) != 0)
          set_lane(l, $urandom_range(0, 7), $urandom_range(0, 7), $urandom_range(0, 7),
                   $urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0);
        cdb_valid[l] = $urandom_range(0, 1) == 1;
        cdb_prd[l*PRW +: PRW] = PRW'($urandom_range(1, 7));
      end
      issue_ready = NF'($urandom);
      flush = $urandom_range(0, 39) == 0;
      rst = $urandom_range(0, 199) == 0;
      settle();
      checks++; if (occupancy !== 4'(exp_occ)) begin failures++; $display("FAIL rand_occ cyc=%0d got=%0d exp=%0d", c, occupancy, exp_occ); end
      checks++; if (rs_full !== exp_full) begin failures++; $display("FAIL rand_full cyc=%0d got=%0b exp=%0b", c, rs_full, exp_full); end
      for (int k = 0; k < NF; k++) begin
        checks++;
        if (issue_valid[k] !== exp_iv[k]) begin
          failures++; $display("FAIL rand_iv cyc=%0d port=%0d got=%0b exp=%0b", c, k, issue_valid[k], exp_iv[k]);
        end else if (exp_iv[k]) begin
          e = q[exp_idx[k]];
          checks++;
          if (issue_rob_id[k*RW +: RW] !== e.rob || issue_prs1[k*PRW +: PRW] !== e.p1 ||
              issue_prs2[k*PRW +: PRW] !== e.p2 || issue_prd[k*PRW +: PRW] !== e.prd ||
              issue_payload[k*PW +: PW] !== e.pl) begin
            failures++;
            $display("FAIL rand_fields cyc=%0d port=%0d got=%0d/%0d/%0d/%0d/%0h exp=%0d/%0d/%0d/%0d/%0h", c, k,
                     issue_rob_id[k*RW +: RW], issue_prs1[k*PRW +: PRW], issue_prs2[k*PRW +: PRW],
                     issue_prd[k*PRW +: PRW], issue_payload[k*PW +: PW], e.rob, e.p1, e.p2, e.prd, e.pl);
          end
        end
      end
      tick();
    end
  endtask

  initial begin
    idle();
    test_reset();
    test_basic();
    test_full();
    test_wakeup();
    test_age_order();
    test_no_sticky();
    test_flush();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
